// File: rtl/cmd_dec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_dec_pkg : shared types and helpers for the command frame decoder
// Revision 1.0
// ---------------------------------------------------------------------------
package cmd_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_REST = 2'd2
  } out_state_e;

  // Number of received bytes that make up one command word.
  function automatic int NB(input int addr_w, input int data_w);
    return (addr_w + data_w) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_fifo : synchronous FIFO, register array with wrap-bit pointers
// Revision 1.0
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_ptr_one = (c_aw + 1)'(1);
  localparam logic [c_aw:0] c_full_lvl = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [c_aw:0]    wr_ptr_q, wr_ptr_d;
  logic [c_aw:0]    rd_ptr_q, rd_ptr_d;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == c_full_lvl);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[c_aw-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[c_aw-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end
    if (rd_en && !empty) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmd_frame_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_frame_decoder : assembles byte frames into address/data commands,
//                     buffers them and presents them on valid/ack with retry
// Revision 1.0
// ---------------------------------------------------------------------------
module cmd_frame_decoder
  import cmd_dec_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               frame,
  input  logic                     frame_valid,
  input  logic                     ack,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        data,
  output logic                     valid,
  output logic                     ovf_err,
  output logic                     sync_err,
  output logic                     drop_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_cmd_w = ADDR_W + DATA_W;
  localparam int c_nb    = NB(ADDR_W, DATA_W);
  localparam int c_gap_w = $clog2(GAP_TIMEOUT + 1);
  localparam int c_cyc_w = $clog2(ACK_TIMEOUT);
  localparam int c_att_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [2:0]         c_last_byte = 3'(c_nb - 1);
  localparam logic [c_gap_w-1:0] c_gap_max   = c_gap_w'(GAP_TIMEOUT);
  localparam logic [c_cyc_w-1:0] c_cyc_last  = c_cyc_w'(ACK_TIMEOUT - 1);
  localparam logic [c_att_w-1:0] c_att_max   = c_att_w'(MAX_RETRY);

  // ---------------- byte assembly ----------------
  logic [c_cmd_w-1:0] asm_q, asm_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [c_gap_w-1:0] gap_q, gap_d;
  logic               ovf_err_q, ovf_err_d;
  logic               sync_err_q, sync_err_d;
  logic [c_cmd_w-1:0] w_shifted;
  logic [2:0]         w_cnt_eff;
  logic               w_gap_to;
  logic               w_push;

  logic [c_cmd_w-1:0] w_rd_data;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;

  generate
    if (c_cmd_w > 8) begin : g_asm_wide
      assign w_shifted = {asm_q[c_cmd_w-9:0], frame};
    end else begin : g_asm_byte
      assign w_shifted = frame;
    end
  endgenerate

  assign w_gap_to  = (byte_cnt_q != 3'd0) && (gap_q == c_gap_max);
  // A byte arriving on the timeout cycle starts a fresh command.
  assign w_cnt_eff = w_gap_to ? 3'd0 : byte_cnt_q;

  always_comb begin
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    w_push     = 1'b0;
    ovf_err_d  = 1'b0;
    sync_err_d = w_gap_to;
    if (w_gap_to) begin
      byte_cnt_d = 3'd0;
      gap_d      = '0;
    end else if (byte_cnt_q != 3'd0) begin
      gap_d = gap_q + c_gap_w'(1);
    end
    if (frame_valid) begin
      gap_d = '0;
      asm_d = w_shifted;
      if (w_cnt_eff == c_last_byte) begin
        byte_cnt_d = 3'd0;
        if (w_full) ovf_err_d = 1'b1;
        else        w_push    = 1'b1;
      end else begin
        byte_cnt_d = w_cnt_eff + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q      <= '0;
      byte_cnt_q <= 3'd0;
      gap_q      <= '0;
      ovf_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      ovf_err_q  <= ovf_err_d;
      sync_err_q <= sync_err_d;
    end
  end

  cmd_fifo #(
    .WIDTH (c_cmd_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_shifted),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  // ---------------- output handshake FSM ----------------
  out_state_e         state_q, state_d;
  logic [c_cyc_w-1:0] cyc_q, cyc_d;
  logic [c_att_w-1:0] att_q, att_d;
  logic               retry_q, retry_d;
  logic               valid_q, valid_d;
  logic               drop_err_q, drop_err_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  data_q, data_d;

  assign w_pop = (state_q == ST_IDLE) && !w_empty;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    att_d      = att_q;
    retry_d    = retry_q;
    valid_d    = valid_q;
    drop_err_d = 1'b0;
    address_d  = address_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          address_d = w_rd_data[c_cmd_w-1 -: ADDR_W];
          data_d    = w_rd_data[DATA_W-1:0];
          valid_d   = 1'b1;
          cyc_d     = '0;
          att_d     = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ack) begin
          valid_d = 1'b0;
          retry_d = 1'b0;
          state_d = ST_REST;
        end else if (cyc_q == c_cyc_last) begin
          valid_d = 1'b0;
          state_d = ST_REST;
          if (att_q < c_att_max) begin
            att_d   = att_q + c_att_w'(1);
            retry_d = 1'b1;
          end else begin
            retry_d    = 1'b0;
            drop_err_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + c_cyc_w'(1);
        end
      end
      ST_REST: begin
        if (retry_q) begin
          valid_d = 1'b1;
          cyc_d   = '0;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      att_q      <= '0;
      retry_q    <= 1'b0;
      valid_q    <= 1'b0;
      drop_err_q <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      att_q      <= att_d;
      retry_q    <= retry_d;
      valid_q    <= valid_d;
      drop_err_q <= drop_err_d;
      address_q  <= address_d;
      data_q     <= data_d;
    end
  end

  assign address  = address_q;
  assign data     = data_q;
  assign valid    = valid_q;
  assign ovf_err  = ovf_err_q;
  assign sync_err = sync_err_q;
  assign drop_err = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmd_frame_decoder : directed bench for cmd_frame_decoder (8/8 and 4/4)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cmd_frame_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] frame;
  logic       frame_valid;
  logic       ack;
  logic [7:0] address;
  logic [7:0] data;
  logic       valid, ovf_err, sync_err, drop_err;
  logic [2:0] level;

  logic [7:0] frame4;
  logic       fv4, ack4;
  logic [3:0] address4, data4;
  logic       valid4, ovf4, sync4, drop4;
  logic [2:0] level4;

  cmd_frame_decoder dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid), .ack(ack),
    .address(address), .data(data), .valid(valid), .ovf_err(ovf_err),
    .sync_err(sync_err), .drop_err(drop_err), .level(level)
  );

  cmd_frame_decoder #(.ADDR_W(4), .DATA_W(4)) dut4 (
    .clk(clk), .rst(rst), .frame(frame4), .frame_valid(fv4), .ack(ack4),
    .address(address4), .data(data4), .valid(valid4), .ovf_err(ovf4),
    .sync_err(sync4), .drop_err(drop4), .level(level4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [4];
  int   passed = 0;
  int   total  = 0;
  int   n_ovf, n_sync, n_drop, n_drop4;
  int   mism, rises, dropk, maxlvl, got, cnt;
  logic prev, expv, ok;
  logic [7:0] exp_a [5];
  logic [7:0] exp_d [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Advance one cycle; sample pulses 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ovf_err)  n_ovf++;
    if (sync_err) n_sync++;
    if (drop_err) n_drop++;
    if (drop4)    n_drop4++;
  endtask

  task automatic send(input logic [7:0] b);
    frame = b;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clear_counts();
    n_ovf = 0; n_sync = 0; n_drop = 0; n_drop4 = 0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};

    rst = 1'b1; frame = 8'h00; frame_valid = 1'b0; ack = 1'b0;
    frame4 = 8'h00; fv4 = 1'b0; ack4 = 1'b0;
    clear_counts();
    tick(); tick();
    check("reset_valid", valid, 0);
    check("reset_level", level, 0);
    check("reset_errs", {ovf_err, sync_err, drop_err}, 0);
    check("reset_addr_data", {address, data}, 0);
    rst = 1'b0;
    tick();

    // Two-byte commands with ack tied high.
    ack = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].b0);
      send(vecs[v].b1);
      check($sformatf("v%0d_t1_valid", v), valid, 0);
      check($sformatf("v%0d_t1_level", v), level, 1);
      tick();
      check($sformatf("v%0d_t2_valid", v), valid, 1);
      check($sformatf("v%0d_addr", v), address, vecs[v].exp_addr);
      check($sformatf("v%0d_data", v), data, vecs[v].exp_data);
      tick();
      check($sformatf("v%0d_t3_valid", v), valid, 0);
      tick(); tick();
    end

    // Ack held low: three 8-cycle attempts with 1-cycle gaps, then drop.
    ack = 1'b0;
    clear_counts();
    send(8'h11);
    send(8'h22);
    mism = 0; rises = 0; dropk = -1; prev = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      expv = ((k >= 2) && (k <= 9)) || ((k >= 11) && (k <= 18)) || ((k >= 20) && (k <= 27));
      if (valid !== expv) mism++;
      if (valid && !prev) rises++;
      prev = valid;
      if (drop_err && dropk < 0) dropk = k;
      tick();
    end
    check("drop_valid_pattern_mism", mism, 0);
    check("drop_attempts", rises, 3);
    check("drop_err_cycle", dropk, 28);
    check("drop_err_count", n_drop, 1);
    check("drop_idle_valid", valid, 0);

    // Overflow: first word is popped into the presenter, four fill the FIFO,
    // the sixth completed word is discarded.
    clear_counts();
    maxlvl = 0;
    for (int c = 0; c < 6; c++) begin
      send(8'((c + 1) << 4));
      if (int'(level) > maxlvl) maxlvl = int'(level);
      send(8'(c + 1));
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    tick();
    if (int'(level) > maxlvl) maxlvl = int'(level);
    tick();
    check("ovf_count", n_ovf, 1);
    check("ovf_max_level", maxlvl, 4);
    check("ovf_level_full", level, 4);
    for (int c = 0; c < 5; c++) begin
      exp_a[c] = 8'((c + 1) << 4);
      exp_d[c] = 8'(c + 1);
    end
    ack = 1'b1;
    got = 0;
    for (int i = 0; i < 120 && got < 5; i++) begin
      if (valid && ack) begin
        check($sformatf("ovf_word%0d", got), {address, data}, {exp_a[got], exp_d[got]});
        got++;
      end
      tick();
    end
    check("ovf_words_out", got, 5);
    tick(); tick();
    check("ovf_drained_level", level, 0);
    check("ovf_no_drop", n_drop, 0);
    check("ovf_single_pulse", n_ovf, 1);

    // Gap timeout: 1023 idle cycles discard the partial byte.
    clear_counts();
    send(8'h12);
    repeat (1023) tick();
    send(8'h34);
    send(8'h56);
    wait_valid(10, ok);
    check("gap_valid_seen", ok, 1);
    check("gap_word", {address, data}, 16'h3456);
    tick(); tick(); tick();
    check("gap_sync_count", n_sync, 1);

    // 1022 idle cycles is still within the allowed gap.
    clear_counts();
    send(8'hAB);
    repeat (1022) tick();
    send(8'hCD);
    wait_valid(10, ok);
    check("nogap_valid_seen", ok, 1);
    check("nogap_word", {address, data}, 16'hABCD);
    tick(); tick(); tick();
    check("nogap_sync_count", n_sync, 0);

    // 4/4 instance: single-byte command, ack on the last timeout cycle.
    clear_counts();
    frame4 = 8'h9E; fv4 = 1'b1;
    tick();
    fv4 = 1'b0;
    check("n1_t1_valid", valid4, 0);
    tick();
    check("n1_t2_valid", valid4, 1);
    check("n1_addr", address4, 4'h9);
    check("n1_data", data4, 4'hE);
    repeat (7) tick();
    check("n1_last_cycle_valid", valid4, 1);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    check("n1_after_ack_valid", valid4, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid4) cnt++;
      tick();
    end
    check("n1_no_retry", cnt, 0);
    check("n1_no_drop", n_drop4, 0);

    // Reset while presenting with two words queued and a partial byte held.
    ack = 1'b0;
    send(8'h31); send(8'h13);
    send(8'h32); send(8'h23);
    send(8'h33); send(8'h33);
    send(8'h77);
    check("rst_pre_valid", valid, 1);
    check("rst_pre_level", level, 2);
    clear_counts();
    rst = 1'b1;
    tick();
    check("rst_mid_valid", valid, 0);
    check("rst_mid_level", level, 0);
    check("rst_mid_errs", {ovf_err, sync_err, drop_err}, 0);
    rst = 1'b0;
    tick();
    check("rst_post_valid", valid, 0);
    send(8'h88);
    send(8'h99);
    wait_valid(10, ok);
    check("rst_post_seen", ok, 1);
    check("rst_post_word", {address, data}, 16'h8899);
    check("rst_no_err_pulses", n_ovf + n_sync + n_drop, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
